// File: rtl/eq_pkg.sv
// Shared constants and types for the equalizer gain loader.
// GAIN_RAMP_EN (optional macro) adds the RAMP state used for stepped gain updates.
package eq_pkg;

   localparam int NUM_BANDS = 8;
   localparam int GAIN_W    = 8;
   localparam int ADDR_W    = 3;
   localparam logic signed [GAIN_W-1:0] UNITY_GAIN = 8'sd64;

   typedef logic signed [GAIN_W-1:0] gain_t;
   typedef gain_t gain_bank_t [NUM_BANDS];

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      PEND  = 2'd1,
      APPLY = 2'd2,
      RAMP  = 2'd3
   } eq_ld_state_t;

endpackage

// File: rtl/eq_gain_step.sv
// One-band gain stepper: moves cur one code toward tgt (signed compare).
// Present only when GAIN_RAMP_EN is defined.
`ifdef GAIN_RAMP_EN
module eq_gain_step
   import eq_pkg::*;
(
   input  logic [GAIN_W-1:0] i_cur,
   input  logic [GAIN_W-1:0] i_tgt,
   output logic [GAIN_W-1:0] o_next,
   output logic              o_eq
);

   gain_t w_cur;
   gain_t w_tgt;

   assign w_cur = gain_t'(i_cur);
   assign w_tgt = gain_t'(i_tgt);

   // o_eq reports that the stepped value has reached the target
   always_comb begin
      o_next = i_cur;
      if (w_cur == w_tgt) begin
         o_next = i_cur;
      end else if (w_cur < w_tgt) begin
         o_next = i_cur + 8'd1;
      end else begin
         o_next = i_cur - 8'd1;
      end
      o_eq = (o_next == i_tgt);
   end

endmodule
`endif

// File: rtl/eq_gain_loader.sv
// Shadow/active gain bank loader; commits only on a sample boundary.
// Define GAIN_RAMP_EN to step active gains by one code per sample instead of copying.
module eq_gain_loader
   import eq_pkg::*;
(
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        cfg_valid,
   output logic                        cfg_ready,
   input  logic [ADDR_W-1:0]           cfg_addr,
   input  logic [GAIN_W-1:0]           cfg_gain,
   input  logic                        cfg_commit,
   input  logic                        sample_stb,
   output logic [NUM_BANDS*GAIN_W-1:0] g_out,
   output logic                        busy,
   output logic                        gain_updated
);

   eq_ld_state_t r_state;
   eq_ld_state_t w_state_nxt;
   gain_bank_t   r_shadow;
   gain_bank_t   r_active;
   gain_bank_t   w_load_val;
   logic         w_beat;
   logic         w_load;
   logic         w_all_eq;

   assign w_beat = cfg_valid && cfg_ready;
   assign w_load = sample_stb && ((r_state == PEND) || (r_state == RAMP));

`ifdef GAIN_RAMP_EN
   gain_t                w_step [NUM_BANDS];
   logic [NUM_BANDS-1:0] w_eq;

   for (genvar gi = 0; gi < NUM_BANDS; gi++) begin : g_step
      eq_gain_step u_step (
         .i_cur  (r_active[gi]),
         .i_tgt  (r_shadow[gi]),
         .o_next (w_step[gi]),
         .o_eq   (w_eq[gi])
      );
   end

   assign w_all_eq   = &w_eq;
   assign w_load_val = w_step;
`else
   assign w_all_eq   = 1'b1;
   assign w_load_val = r_shadow;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic; a strobe in the commit cycle is seen while still IDLE, so it is ignored
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE: begin
            if (w_beat && cfg_commit) begin
               w_state_nxt = PEND;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         PEND, RAMP: begin
            if (!sample_stb) begin
               w_state_nxt = r_state;
            end else if (w_all_eq) begin
               w_state_nxt = APPLY;
            end else begin
               w_state_nxt = RAMP;
            end
         end
         APPLY:   w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // Output decode from the registered state
   always_comb begin
      cfg_ready    = 1'b0;
      busy         = 1'b0;
      gain_updated = 1'b0;
      case (r_state)
         IDLE:    cfg_ready    = 1'b1;
         PEND:    busy         = 1'b1;
         RAMP:    busy         = 1'b1;
         APPLY:   gain_updated = 1'b1;
         default: cfg_ready    = 1'b0;
      endcase
   end

   // Shadow bank; out-of-range addresses match no band and are dropped
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_BANDS; i++) begin
            r_shadow[i] <= UNITY_GAIN;
         end
      end else if (w_beat) begin
         for (int i = 0; i < NUM_BANDS; i++) begin
            if (cfg_addr == ADDR_W'(i)) begin
               r_shadow[i] <= gain_t'(cfg_gain);
            end
         end
      end
   end

   // Active bank, updated only on a sample strobe while a commit is outstanding
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < NUM_BANDS; i++) begin
            r_active[i] <= UNITY_GAIN;
         end
      end else if (w_load) begin
         for (int i = 0; i < NUM_BANDS; i++) begin
            r_active[i] <= w_load_val[i];
         end
      end
   end

   for (genvar gi = 0; gi < NUM_BANDS; gi++) begin : g_flat
      assign g_out[gi*GAIN_W +: GAIN_W] = r_active[gi];
   end

endmodule

// File: tb/tb_eq_gain_loader.sv
// Directed + randomized bench for eq_gain_loader with a transaction-level gain model.
module tb_eq_gain_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [2:0]  cfg_addr;
   logic [7:0]  cfg_gain;
   logic        cfg_commit;
   logic        sample_stb;
   logic [63:0] g_out;
   logic        busy;
   logic        gain_updated;

   int n_checks = 0;
   int n_errors = 0;

   // reference: requested set, visible set, and whether an apply is outstanding
   logic [7:0] m_req [8];
   logic [7:0] m_vis [8];
   bit         m_pending;
   bit         m_done_pulse;

   always #5 clk = ~clk;

   eq_gain_loader dut (
      .clk          (clk),
      .rst          (rst),
      .cfg_valid    (cfg_valid),
      .cfg_ready    (cfg_ready),
      .cfg_addr     (cfg_addr),
      .cfg_gain     (cfg_gain),
      .cfg_commit   (cfg_commit),
      .sample_stb   (sample_stb),
      .g_out        (g_out),
      .busy         (busy),
      .gain_updated (gain_updated)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp)
      else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [7:0] band(input int i);
      return g_out[i*8 +: 8];
   endfunction

   // model the effect of one clock edge given the inputs the bench applied
   task automatic model_edge();
      bit accepted;
      bit all_eq;
      accepted = cfg_valid && !m_pending && !m_done_pulse;
      if (rst) begin
         foreach (m_req[i]) begin
            m_req[i] = 8'd64;
            m_vis[i] = 8'd64;
         end
         m_pending    = 1'b0;
         m_done_pulse = 1'b0;
      end else if (m_done_pulse) begin
         m_done_pulse = 1'b0;
      end else if (m_pending) begin
         if (sample_stb) begin
`ifdef GAIN_RAMP_EN
            all_eq = 1'b1;
            foreach (m_vis[i]) begin
               if ($signed(m_vis[i]) < $signed(m_req[i])) m_vis[i] = m_vis[i] + 8'd1;
               else if ($signed(m_vis[i]) > $signed(m_req[i])) m_vis[i] = m_vis[i] - 8'd1;
               if (m_vis[i] != m_req[i]) all_eq = 1'b0;
            end
`else
            all_eq = 1'b1;
            foreach (m_vis[i]) m_vis[i] = m_req[i];
`endif
            if (all_eq) begin
               m_pending    = 1'b0;
               m_done_pulse = 1'b1;
            end
         end
      end else if (accepted) begin
         m_req[cfg_addr] = cfg_gain;
         if (cfg_commit) m_pending = 1'b1;
      end
   endtask

   task automatic check_all(input string ctx);
      for (int i = 0; i < 8; i++) begin
         chk($sformatf("%s g_out[%0d]", ctx, i), {24'd0, band(i)}, {24'd0, m_vis[i]});
      end
      chk({ctx, " cfg_ready"}, {31'd0, cfg_ready}, {31'd0, !m_pending && !m_done_pulse});
      chk({ctx, " busy"}, {31'd0, busy}, {31'd0, m_pending});
      chk({ctx, " gain_updated"}, {31'd0, gain_updated}, {31'd0, m_done_pulse});
   endtask

   task automatic cyc(input string ctx, input logic v, input logic [2:0] a,
                      input logic [7:0] g, input logic c, input logic s);
      cfg_valid  = v;
      cfg_addr   = a;
      cfg_gain   = g;
      cfg_commit = c;
      sample_stb = s;
      @(posedge clk);
      model_edge();
      #1;
      check_all(ctx);
   endtask

   task automatic idle(input string ctx, input int n);
      for (int k = 0; k < n; k++) cyc(ctx, 1'b0, 3'd0, 8'd0, 1'b0, 1'b0);
   endtask

   initial begin
      rst = 1'b1;
      cfg_valid = 1'b0; cfg_addr = 3'd0; cfg_gain = 8'd0; cfg_commit = 1'b0; sample_stb = 1'b0;
      foreach (m_req[i]) begin
         m_req[i] = 8'd0;
         m_vis[i] = 8'd0;
      end
      m_pending = 1'b0;
      m_done_pulse = 1'b0;

      // reset for two cycles
      idle("reset", 2);
      rst = 1'b0;
      chk("reset band0 unity", {24'd0, band(0)}, 32'd64);

      // shadow writes without commit never reach g_out
      cyc("wr3", 1'b1, 3'd3, 8'hEC, 1'b0, 1'b0);
      cyc("wr7", 1'b1, 3'd7, 8'd100, 1'b0, 1'b0);
      for (int k = 0; k < 3; k++) cyc("stb_nocommit", 1'b0, 3'd0, 8'd0, 1'b0, 1'b1);
      cyc("commit0", 1'b1, 3'd0, 8'd10, 1'b1, 1'b0);
      cyc("apply_stb", 1'b0, 3'd0, 8'd0, 1'b0, 1'b1);
`ifndef GAIN_RAMP_EN
      chk("apply band3", {24'd0, band(3)}, 32'h0000_00EC);
      chk("apply band7", {24'd0, band(7)}, 32'd100);
      chk("apply band0", {24'd0, band(0)}, 32'd10);
      chk("apply pulse", {31'd0, gain_updated}, 32'd1);
`endif
      idle("post_apply", 40);

      // commit in the strobe cycle; cfg_valid held high through PEND
      cyc("commit_with_stb", 1'b1, 3'd1, 8'd33, 1'b1, 1'b1);
      for (int k = 0; k < 11; k++) cyc("pend_hold", 1'b1, 3'd1, 8'd77, 1'b0, 1'b0);
      cyc("late_stb", 1'b1, 3'd1, 8'd77, 1'b0, 1'b1);
      cyc("after_late_stb", 1'b1, 3'd2, 8'd5, 1'b0, 1'b0);
      idle("post3", 4);

      // last write to a band wins
      cyc("b3_first", 1'b1, 3'd3, 8'd5, 1'b0, 1'b0);
      cyc("b3_second", 1'b1, 3'd3, 8'hF9, 1'b1, 1'b0);
      cyc("b3_stb", 1'b0, 3'd0, 8'd0, 1'b0, 1'b1);
      idle("post4", 12);
`ifndef GAIN_RAMP_EN
      chk("last write wins band3", {24'd0, band(3)}, 32'h0000_00F9);
`endif

      // reset while pending aborts the apply
      cyc("pend_reset_commit", 1'b1, 3'd1, 8'hFF, 1'b1, 1'b0);
      idle("pend_wait", 3);
      rst = 1'b1;
      idle("pend_in_reset", 2);
      rst = 1'b0;
      cyc("stb_after_reset", 1'b0, 3'd0, 8'd0, 1'b0, 1'b1);
      idle("post5", 2);
      chk("aborted band1", {24'd0, band(1)}, 32'd64);

`ifdef GAIN_RAMP_EN
      // ramp: band2 64->61, band5 64->66
      cyc("ramp_wr2", 1'b1, 3'd2, 8'd61, 1'b0, 1'b0);
      cyc("ramp_wr5", 1'b1, 3'd5, 8'd66, 1'b1, 1'b0);
      cyc("ramp_s1", 1'b0, 3'd0, 8'd0, 1'b0, 1'b1);
      chk("ramp s1 band2", {24'd0, band(2)}, 32'd63);
      chk("ramp s1 band5", {24'd0, band(5)}, 32'd65);
      idle("ramp_gap", 2);
      cyc("ramp_s2", 1'b0, 3'd0, 8'd0, 1'b0, 1'b1);
      chk("ramp s2 band2", {24'd0, band(2)}, 32'd62);
      chk("ramp s2 band5", {24'd0, band(5)}, 32'd66);
      chk("ramp s2 busy", {31'd0, busy}, 32'd1);
      idle("ramp_gap", 2);
      cyc("ramp_s3", 1'b0, 3'd0, 8'd0, 1'b0, 1'b1);
      chk("ramp s3 band2", {24'd0, band(2)}, 32'd61);
      chk("ramp s3 pulse", {31'd0, gain_updated}, 32'd1);
      idle("ramp_done", 3);
`endif

      // randomized traffic
      for (int k = 0; k < 400; k++) begin
         cyc("random", 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
             8'($urandom_range(40, 90)), ($urandom_range(0, 5) == 0),
             ($urandom_range(0, 3) == 0));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
